// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: state encoding, ls_size codes,
// default IO region select and the size-to-byte-count helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  // Illegal size code 3 is treated as a full word.
  function automatic logic [4:0] size_bytes(input logic [1:0] size);
    logic [4:0] n;
    case (size)
      SZ_BYTE: n = 5'd1;
      SZ_HALF: n = 5'd2;
      SZ_WORD: n = 5'd4;
      default: n = 5'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between the fetch unit and the load/store unit.
// MEM_ARB_RR_EN defined: round-robin on conflict; otherwise ls always wins.
module mem_arb_grant (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_grant_en,
  input  logic i_if_req,
  input  logic i_ls_req,
  output logic o_grant_ls,
  output logic o_grant_if
);

`ifdef MEM_ARB_RR_EN
  // Requester that wins the next conflict; starts at ls.
  logic r_prio_ls;

  // Pick a winner; the pointer only matters when both requests are pending.
  always_comb begin
    o_grant_ls = 1'b0;
    o_grant_if = 1'b0;
    if (i_grant_en) begin
      if (i_ls_req && i_if_req) begin
        o_grant_ls = r_prio_ls;
        o_grant_if = !r_prio_ls;
      end else begin
        o_grant_ls = i_ls_req;
        o_grant_if = i_if_req;
      end
    end
  end

  // Hand priority to the other requester after every grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio_ls <= 1'b1;
    end else if (o_grant_ls) begin
      r_prio_ls <= 1'b0;
    end else if (o_grant_if) begin
      r_prio_ls <= 1'b1;
    end
  end
`else
  logic w_unused;

  // Fixed priority: ls over if.
  always_comb begin
    o_grant_ls = i_grant_en && i_ls_req;
    o_grant_if = i_grant_en && i_if_req && !i_ls_req;
  end

  assign w_unused = i_clk ^ i_rst;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between instruction fetch and load/store.
// Multi-byte requests become per-byte RAM cycles; IO writes stall on a full
// UART buffer; non-IO reads abort on flush. Optional feature macro:
// MEM_ARB_RR_EN (round-robin grant, see mem_arb_grant).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned IF_BYTES = 4,
  parameter logic [1:0]  IO_SEL   = IO_SEL_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  output logic                    if_done,
  output logic [8*IF_BYTES-1:0]   if_data,
  input  logic                    ls_req,
  input  logic                    ls_wr,
  input  logic [1:0]              ls_size,
  input  logic [31:0]             ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int unsigned DataW = (IF_BYTES > 4) ? 8 * IF_BYTES : 32;

  logic [1:0]       r_state;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [4:0]       r_nbytes;
  logic [4:0]       r_idx;      // bytes addressed so far
  logic             r_is_ls;
  logic [DataW-1:0] r_data;

  logic w_grant_en;
  logic w_grant_ls;
  logic w_grant_if;
  logic w_is_io;
  logic w_io_stall;

  assign w_grant_en = rdy_in && (r_state == ST_IDLE);
  assign w_is_io    = (r_addr[17:16] == IO_SEL);
  assign w_io_stall = w_is_io && io_buffer_full;

  mem_arb_grant u_grant (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_grant_en (w_grant_en),
    .i_if_req   (if_req),
    .i_ls_req   (ls_req),
    .o_grant_ls (w_grant_ls),
    .o_grant_if (w_grant_if)
  );

  // Transfer sequencing: latch arguments at grant, step bytes, capture read data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= ST_IDLE;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_nbytes <= 5'd0;
      r_idx    <= 5'd0;
      r_is_ls  <= 1'b1;
      r_data   <= '0;
    end else if (rdy_in) begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_ls) begin
            r_addr   <= ls_addr;
            r_wdata  <= ls_wdata;
            r_nbytes <= size_bytes(ls_size);
            r_is_ls  <= 1'b1;
            r_idx    <= 5'd0;
            r_data   <= '0;
            r_state  <= ls_wr ? ST_WRITE : ST_READ;
          end else if (w_grant_if) begin
            r_addr   <= if_addr;
            r_wdata  <= 32'h0;
            r_nbytes <= 5'(IF_BYTES);
            r_is_ls  <= 1'b0;
            r_idx    <= 5'd0;
            r_data   <= '0;
            r_state  <= ST_READ;
          end
        end
        ST_READ: begin
          // IO reads run to completion: the UART pop cannot be undone.
          if (flush_in && !w_is_io) begin
            r_state <= ST_IDLE;
          end else begin
            // mem_din carries the byte addressed one cycle earlier.
            if (r_idx != 5'd0) begin
              r_data[{r_idx - 5'd1, 3'b000} +: 8] <= mem_din;
            end
            if (r_idx == r_nbytes) begin
              r_state <= ST_DONE;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        ST_WRITE: begin
          if (!w_io_stall) begin
            if (r_idx == r_nbytes - 5'd1) begin
              r_state <= ST_DONE;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end else if (r_state == ST_READ) begin
      // A pause breaks the read pipeline, so restart from byte 0.
      r_idx <= 5'd0;
    end
  end

  // RAM port drive; address is parked at 0 outside active byte cycles.
  always_comb begin
    mem_a    = 32'h0;
    mem_dout = 8'h0;
    mem_wr   = 1'b0;
    if ((r_state == ST_READ) && (r_idx < r_nbytes)) begin
      mem_a = r_addr + {27'b0, r_idx};
    end else if (r_state == ST_WRITE) begin
      mem_a    = r_addr + {27'b0, r_idx};
      mem_dout = r_wdata[{r_idx[1:0], 3'b000} +: 8];
      mem_wr   = rdy_in && !w_io_stall;
    end
  end

  // Done pulses and result data.
  always_comb begin
    if_done  = (r_state == ST_DONE) && !r_is_ls && rdy_in;
    ls_done  = (r_state == ST_DONE) && r_is_ls && rdy_in;
    if_data  = r_data[8*IF_BYTES-1:0];
    ls_rdata = r_data[31:0];
  end

endmodule
